// File: rtl/arf096b256e1r1w0cbbeheaa4acw_rd_pipe.sv
// Read pipe for the 96b x 256 1R1W regfile. Request to response takes ARRAY_LAT+2 cycles. Credit-gated req_ready means a read is only issued once a FIFO slot is reserved for it.
// Optional parity checking is enabled by ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN.
module arf096b256e1r1w0cbbeheaa4acw_rd_pipe #(
  parameter int DWIDTH     = 96,
  parameter int DEPTH      = 256,
  parameter int AWIDTH     = 8,
  parameter int ARRAY_LAT  = 1,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              arr_rden,
  output logic [AWIDTH-1:0] arr_rdaddr,
  input  logic [DWIDTH-1:0] arr_rddata,
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
  input  logic              arr_rdpar,
  output logic              rsp_perr,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_oor,
  output logic              busy
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int IW = $clog2(ARRAY_LAT + 2);

  typedef struct packed {
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
    logic              perr;
`endif
    logic              oor;
    logic [DWIDTH-1:0] data;
  } ent_t;

  logic [ARRAY_LAT:0] pv;
  logic [ARRAY_LAT:0] poor;
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      count;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  ent_t               mem [OBUF_DEPTH];
  ent_t               wr_ent;
  logic               accept;
  logic               req_oor;
  logic               push;
  logic               pop;
  logic [31:0]        occ;

  // A credit is consumed at accept and returned at pop, so the FIFO can never overflow.
  assign occ       = 32'(count) + 32'(inflight);
  assign req_ready = occ < 32'(OBUF_DEPTH);
  assign req_oor   = 32'(req_addr) >= 32'(DEPTH);
  assign accept    = req_valid & req_ready;
  assign push      = pv[ARRAY_LAT];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (inflight != '0) | (count != '0);

  always_comb begin
    wr_ent     = '0;
    wr_ent.oor = poor[ARRAY_LAT];
    if (!poor[ARRAY_LAT]) begin
      wr_ent.data = arr_rddata;
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
      wr_ent.perr = ^{arr_rddata, arr_rdpar};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arr_rden   <= 1'b0;
      arr_rdaddr <= '0;
      pv         <= '0;
      poor       <= '0;
      inflight   <= '0;
    end else begin
      arr_rden <= accept & ~req_oor;
      if (accept & ~req_oor)
        arr_rdaddr <= req_addr;
      pv       <= {pv[ARRAY_LAT-1:0], accept};
      poor     <= {poor[ARRAY_LAT-1:0], req_oor};
      inflight <= inflight + IW'(accept) - IW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_ent;
        wptr      <= (wptr == PW'(OBUF_DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop)
        rptr <= (rptr == PW'(OBUF_DEPTH - 1)) ? '0 : rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rsp_data = mem[rptr].data;
  assign rsp_oor  = mem[rptr].oor;
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
  assign rsp_perr = mem[rptr].perr;
`endif

endmodule

// File: tb/tb_arf096b256e1r1w0cbbeheaa4acw_rd_pipe.sv
// Scoreboard bench for the regfile read pipe; a behavioural array returns data one cycle after arr_rden.
module tb_arf096b256e1r1w0cbbeheaa4acw_rd_pipe;

  localparam int DW  = 96;
  localparam int DEP = 96;
  localparam int AW  = 8;
  localparam int LAT = 1;
  // Four entries cover the LAT+2 credit round trip so back-to-back issue never stalls.
  localparam int OBD = 4;

  typedef struct packed {
    logic          oor;
    logic          perr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          arr_rden;
  logic [AW-1:0] arr_rdaddr;
  logic [DW-1:0] arr_rddata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_oor;
  logic          busy;
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
  logic          arr_rdpar = 1'b0;
  logic          rsp_perr;
  logic          par_force = 1'b0;
  logic          par_val = 1'b0;
`endif

  logic [DW-1:0] mem [256];
  exp_t          sbq[$];
  int            pop_cyc[$];
  exp_t          mon_e;
  exp_t          mon_a;
  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  int            cyc = 0;

  arf096b256e1r1w0cbbeheaa4acw_rd_pipe #(
    .DWIDTH(DW), .DEPTH(DEP), .AWIDTH(AW), .ARRAY_LAT(LAT), .OBUF_DEPTH(OBD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .arr_rden(arr_rden),
    .arr_rdaddr(arr_rdaddr),
    .arr_rddata(arr_rddata),
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
    .arr_rdpar(arr_rdpar),
    .rsp_perr(rsp_perr),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_oor(rsp_oor),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: junk on idle cycles so zero-forcing of oor entries is exercised.
  always @(posedge clk) begin
    if (arr_rden) arr_rddata <= mem[arr_rdaddr];
    else          arr_rddata <= {$urandom, $urandom, $urandom};
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
    if (arr_rden) arr_rdpar <= par_force ? par_val : ^mem[arr_rdaddr];
    else          arr_rdpar <= 1'($urandom);
`endif
  end

  // Response monitor: every pop is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      pops++;
      pop_cyc.push_back(cyc);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got oor=%0b data=%h want no response", rsp_oor, rsp_data);
      end else begin
        mon_e = sbq.pop_front();
        mon_a = '0;
        mon_a.oor  = rsp_oor;
        mon_a.data = rsp_data;
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
        mon_a.perr = rsp_perr;
`endif
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL rsp_data got oor=%0b perr=%0b data=%h want oor=%0b perr=%0b data=%h",
                   mon_a.oor, mon_a.perr, mon_a.data, mon_e.oor, mon_e.perr, mon_e.data);
        end
      end
    end
  end

  function automatic exp_t expect_of(input int a);
    exp_t e;
    e = '0;
    if (a >= DEP) e.oor = 1'b1;
    else          e.data = mem[a];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (arr_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %0b want 0", arr_rden); end
    checks++; if (arr_rdaddr !== '0) begin errors++; $display("FAIL reset_rdaddr got %h want 0", arr_rdaddr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    checks++; if (rsp_oor !== 1'b0) begin errors++; $display("FAIL reset_rsp_oor got %0b want 0", rsp_oor); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    int p0;
    rsp_ready = 1'b1;
    req_addr  = 8'd5;
    req_valid = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", req_ready); end
    sbq.push_back(expect_of(5));
    p0 = pops;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({arr_rden, arr_rdaddr} !== {1'b1, 8'd5}) begin
      errors++; $display("FAIL single_issue got rden=%0b addr=%h want rden=1 addr=05", arr_rden, arr_rdaddr);
    end
    tick(); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %0b want 0", rsp_valid); end
    tick(); @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0b want 1", rsp_valid); end
    tick(); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", busy); end
    checks++; if (pops !== p0 + 1) begin errors++; $display("FAIL single_pops got %0d want %0d", pops, p0 + 1); end
    tick();
  endtask

  task automatic test_back_to_back();
    int rden_n = 0;
    int rden_first = -1;
    int rden_last = -1;
    rsp_ready = 1'b1;
    pop_cyc.delete();
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8);
      req_addr  = AW'(c);
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready req %0d got %0b want 1", c, req_ready); end
        sbq.push_back(expect_of(c));
      end
      if (arr_rden === 1'b1) begin
        rden_n++;
        if (rden_first < 0) rden_first = cyc;
        rden_last = cyc;
      end
      tick();
    end
    req_valid = 1'b0;
    checks++; if (rden_n != 8) begin errors++; $display("FAIL b2b_rden_count got %0d want 8", rden_n); end
    checks++; if (rden_last - rden_first != 7) begin errors++; $display("FAIL b2b_rden_span got %0d want 7", rden_last - rden_first); end
    checks++;
    if (pop_cyc.size() != 8) begin
      errors++; $display("FAIL b2b_rsp_count got %0d want 8", pop_cyc.size());
    end else if (pop_cyc[7] - pop_cyc[0] != 7) begin
      errors++; $display("FAIL b2b_rsp_span got %0d want 7", pop_cyc[7] - pop_cyc[0]);
    end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL b2b_left got %0d want 0", sbq.size()); end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (nxt < 5);
      req_addr  = AW'(10 + nxt);
      @(negedge clk);
      if (req_valid && req_ready) begin
        sbq.push_back(expect_of(10 + nxt));
        nxt++;
      end
      tick();
    end
    @(negedge clk);
    checks++; if (nxt != OBD) begin errors++; $display("FAIL bp_accepted got %0d want %0d", nxt, OBD); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b want 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %0b want 1", busy); end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if ({rsp_valid, rsp_oor, rsp_data} !== {1'b1, sbq[0].oor, sbq[0].data}) begin
        errors++; $display("FAIL bp_hold got v=%0b data=%h want v=1 data=%h", rsp_valid, rsp_data, sbq[0].data);
      end
      tick(); @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle got %0b want 0", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %0b want 1", req_ready); end
    sbq.push_back(expect_of(10 + nxt));
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 20 && (sbq.size() != 0 || busy); k++) tick();
    @(negedge clk);
    checks++;
    if (sbq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_drain got left=%0d busy=%0b want left=0 busy=0", sbq.size(), busy);
    end
    tick();
  endtask

  task automatic test_oor();
    int al[3];
    int rden_n = 0;
    int bad = 0;
    al[0] = 20; al[1] = 100; al[2] = 21;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 3);
      req_addr  = (c < 3) ? AW'(al[c]) : '0;
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL oor_ready req %0d got %0b want 1", c, req_ready); end
        sbq.push_back(expect_of(al[c]));
      end
      if (arr_rden === 1'b1) begin
        rden_n++;
        if (arr_rdaddr == 8'd100) bad++;
      end
      tick();
    end
    req_valid = 1'b0;
    checks++; if (rden_n != 2) begin errors++; $display("FAIL oor_rden_count got %0d want 2", rden_n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL oor_issued got %0d want 0", bad); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL oor_left got %0d want 0", sbq.size()); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 8'd30;
    @(negedge clk); sbq.push_back(expect_of(30));
    tick();
    req_addr = 8'd31;
    @(negedge clk); sbq.push_back(expect_of(31));
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b want 1", req_ready); end
    for (int k = 0; k < 6; k++) begin
      tick(); @(negedge clk);
      if (rsp_valid === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rmid_stale got %0d want 0", stray); end
    tick();
    req_valid = 1'b1;
    req_addr  = 8'd40;
    @(negedge clk); sbq.push_back(expect_of(40));
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL rmid_recover got %0d want 0", sbq.size()); end
  endtask

`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
  task automatic test_parity();
    exp_t e;
    mem[50]   = 96'h1;
    rsp_ready = 1'b1;
    par_force = 1'b1;
    for (int p = 0; p < 2; p++) begin
      par_val   = 1'(p);
      e         = '0;
      e.data    = 96'h1;
      e.perr    = (p == 0);
      req_valid = 1'b1;
      req_addr  = 8'd50;
      @(negedge clk); sbq.push_back(e);
      tick();
      req_valid = 1'b0;
      repeat (5) tick();
    end
    par_force = 1'b0;
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL parity_left got %0d want 0", sbq.size()); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[5] = 96'h0A5A_0A5A_0A5A_0A5A_0A5A_0A5A;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_oor();
    test_reset_mid();
`ifdef ARF096B256E1R1W0CBBEHEAA4ACW_RD_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
